// File: rtl/div_pkg.sv
// Shared widths, latency and tag layout for the divider scheduler.
package div_pkg;
    localparam int M = 26;
    localparam int N = 14;
    localparam int LAT = M - N;
    localparam int DEPTH = 16;
    localparam logic [M-1:0] DZ_QUOTIENT = {M{1'b1}};

    typedef struct packed {
        logic valid;
        logic id;
        logic dz;
    } tag_t;
endpackage

// File: rtl/div_result_fifo.sv
// Synchronous result FIFO; caller never pushes when full or pops when empty.
module div_result_fifo #(
    parameter int WIDTH = 27,
    parameter int ENTRIES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             not_empty
);
    localparam int AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CW = $clog2(ENTRIES + 1);

    logic [WIDTH-1:0] mem_q [ENTRIES];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        count_d = count_q;
        if (push) begin
            wr_d = (wr_q == AW'(ENTRIES - 1)) ? '0 : wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = (rd_q == AW'(ENTRIES - 1)) ? '0 : rd_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_q];
    assign not_empty = (count_q != '0);
endmodule

// File: rtl/div_scheduler.sv
// Round-robin sharing of one pipelined divider between two requesters,
// with credit-based flow control into per-requester result FIFOs.
module div_scheduler
    import div_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [M-1:0] req0_dividend,
    input  logic [N-1:0] req0_divisor,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [M-1:0] req1_dividend,
    input  logic [N-1:0] req1_divisor,
    output logic         res0_valid,
    input  logic         res0_ready,
    output logic [M-1:0] res0_quotient,
    output logic         res0_dz,
    output logic         res1_valid,
    input  logic         res1_ready,
    output logic [M-1:0] res1_quotient,
    output logic         res1_dz,
    output logic [M-1:0] div_dividend,
    output logic [N-1:0] div_divisor,
    input  logic [M-1:0] div_quotient,
    output logic         busy
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] credit0_q, credit0_d;
    logic [CW-1:0] credit1_q, credit1_d;
    logic          prio_q, prio_d;
    logic [M-1:0]  div_dividend_q, div_dividend_d;
    logic [N-1:0]  div_divisor_q, div_divisor_d;
    tag_t          tag_q [LAT+1];
    tag_t          tag_d [LAT+1];

    logic elig0, elig1, grant0, grant1;
    logic pop0, pop1, push0, push1;
    logic nempty0, nempty1, tags_busy;
    tag_t tag_out;
    logic [M:0] push_data, pop_data0, pop_data1;

    always_comb begin
        elig0 = rst_n && req0_valid && (credit0_q != '0);
        elig1 = rst_n && req1_valid && (credit1_q != '0);
        grant0 = elig0 && (!elig1 || !prio_q);
        grant1 = elig1 && (!elig0 || prio_q);
        prio_d = prio_q;
        if (grant0) begin
            prio_d = 1'b1;
        end else if (grant1) begin
            prio_d = 1'b0;
        end
    end

    // Credits reserve a FIFO slot at issue, so a push can never overflow.
    always_comb begin
        credit0_d = credit0_q;
        credit1_d = credit1_q;
        if (grant0 && !pop0) begin
            credit0_d = credit0_q - 1'b1;
        end else if (!grant0 && pop0) begin
            credit0_d = credit0_q + 1'b1;
        end
        if (grant1 && !pop1) begin
            credit1_d = credit1_q - 1'b1;
        end else if (!grant1 && pop1) begin
            credit1_d = credit1_q + 1'b1;
        end
    end

    always_comb begin
        div_dividend_d = '0;
        div_divisor_d = N'(1);
        tag_d[0] = '0;
        unique case (1'b1)
            grant0: begin
                div_dividend_d = req0_dividend;
                if (req0_divisor != '0) begin
                    div_divisor_d = req0_divisor;
                end
                tag_d[0] = '{valid: 1'b1, id: 1'b0,
                             dz: (req0_divisor == '0)};
            end
            grant1: begin
                div_dividend_d = req1_dividend;
                if (req1_divisor != '0) begin
                    div_divisor_d = req1_divisor;
                end
                tag_d[0] = '{valid: 1'b1, id: 1'b1,
                             dz: (req1_divisor == '0)};
            end
            default: ;
        endcase
        for (int i = 1; i <= LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit0_q <= CW'(DEPTH);
            credit1_q <= CW'(DEPTH);
            prio_q <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q <= N'(1);
            for (int i = 0; i <= LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            credit0_q <= credit0_d;
            credit1_q <= credit1_d;
            prio_q <= prio_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q <= div_divisor_d;
            for (int i = 0; i <= LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    always_comb begin
        tags_busy = 1'b0;
        for (int i = 0; i <= LAT; i++) begin
            tags_busy = tags_busy | tag_q[i].valid;
        end
    end

    // tag_q[LAT] lines up with the quotient of the op it describes.
    assign tag_out = tag_q[LAT];
    assign push0 = rst_n && tag_out.valid && !tag_out.id;
    assign push1 = rst_n && tag_out.valid && tag_out.id;
    assign push_data = {tag_out.dz ? DZ_QUOTIENT : div_quotient,
                        tag_out.dz};

    assign pop0 = rst_n && nempty0 && res0_ready;
    assign pop1 = rst_n && nempty1 && res1_ready;

    div_result_fifo #(
        .WIDTH(M + 1),
        .ENTRIES(DEPTH)
    ) u_fifo0 (
        .clk(clk),
        .rst_n(rst_n),
        .push(push0),
        .push_data(push_data),
        .pop(pop0),
        .pop_data(pop_data0),
        .not_empty(nempty0)
    );

    div_result_fifo #(
        .WIDTH(M + 1),
        .ENTRIES(DEPTH)
    ) u_fifo1 (
        .clk(clk),
        .rst_n(rst_n),
        .push(push1),
        .push_data(push_data),
        .pop(pop1),
        .pop_data(pop_data1),
        .not_empty(nempty1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign res0_valid = rst_n && nempty0;
    assign res1_valid = rst_n && nempty1;
    assign res0_quotient = pop_data0[M:1];
    assign res0_dz = pop_data0[0];
    assign res1_quotient = pop_data1[M:1];
    assign res1_dz = pop_data1[0];
    assign div_dividend = div_dividend_q;
    assign div_divisor = div_divisor_q;
    assign busy = rst_n && (tags_busy || nempty0 || nempty1);
endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler with a behavioural pipelined divider and
// a queue-based reference model of both requester streams.
module tb_div_scheduler;
    import div_pkg::*;

    localparam int EXP_LAT = 14;

    typedef struct {
        logic [25:0] q;
        logic        dz;
        int          cyc;
    } exp_t;

    logic clk, rst_n;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [M-1:0] req0_dividend, req1_dividend;
    logic [N-1:0] req0_divisor, req1_divisor;
    logic res0_valid, res0_ready, res0_dz;
    logic res1_valid, res1_ready, res1_dz;
    logic [M-1:0] res0_quotient, res1_quotient;
    logic [M-1:0] div_dividend, div_quotient;
    logic [N-1:0] div_divisor;
    logic busy;

    int n_cmp, n_fail;
    int cyc;
    int acc0, acc1, pop0_cnt, pop1_cnt, zero_seen;
    int lat0_last, lat1_last;
    logic [25:0] last_q0, last_q1;
    logic last_dz0, last_dz1;
    bit started;
    exp_t exp0[$];
    exp_t exp1[$];
    int glog[$];

    div_scheduler dut (
        .clk(clk),
        .rst_n(rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_dividend(req0_dividend),
        .req0_divisor(req0_divisor),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_dividend(req1_dividend),
        .req1_divisor(req1_divisor),
        .res0_valid(res0_valid),
        .res0_ready(res0_ready),
        .res0_quotient(res0_quotient),
        .res0_dz(res0_dz),
        .res1_valid(res1_valid),
        .res1_ready(res1_ready),
        .res1_quotient(res1_quotient),
        .res1_dz(res1_dz),
        .div_dividend(div_dividend),
        .div_divisor(div_divisor),
        .div_quotient(div_quotient),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider stand-in: no reset, no stall, LAT edges from sample to output.
    logic [M-1:0] dpipe [LAT];
    always @(posedge clk) begin
        dpipe[0] <= (div_divisor == '0) ? '1 : div_dividend / div_divisor;
        for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign div_quotient = dpipe[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t ref_op(input logic [25:0] dd,
                                    input logic [13:0] dv, input int c);
        exp_t e;
        e.cyc = c;
        if (dv == 0) begin
            e.q = 26'h3FFFFFF;
            e.dz = 1'b1;
        end else begin
            e.q = dd / {12'd0, dv};
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: record accepts, check every consumed result in order.
    always @(negedge clk) begin
        exp_t e;
        if (started && div_divisor == '0) zero_seen++;
        if (req0_valid && req0_ready) begin
            exp0.push_back(ref_op(req0_dividend, req0_divisor, cyc));
            acc0++;
            glog.push_back(0);
        end
        if (req1_valid && req1_ready) begin
            exp1.push_back(ref_op(req1_dividend, req1_divisor, cyc));
            acc1++;
            glog.push_back(1);
        end
        if (res0_valid && res0_ready) begin
            pop0_cnt++;
            last_q0 = res0_quotient;
            last_dz0 = res0_dz;
            n_cmp++;
            if (exp0.size() == 0) begin
                n_fail++;
                $display("FAIL res0_unexpected: got q=%h dz=%b, required none",
                         res0_quotient, res0_dz);
            end else begin
                e = exp0.pop_front();
                if (res0_quotient !== e.q || res0_dz !== e.dz) begin
                    n_fail++;
                    $display("FAIL res0_data: got q=%h dz=%b, required q=%h dz=%b",
                             res0_quotient, res0_dz, e.q, e.dz);
                end
                lat0_last = cyc - e.cyc;
                n_cmp++;
                if (lat0_last < EXP_LAT) begin
                    n_fail++;
                    $display("FAIL res0_latency: got %0d, required >= %0d",
                             lat0_last, EXP_LAT);
                end
            end
        end
        if (res1_valid && res1_ready) begin
            pop1_cnt++;
            last_q1 = res1_quotient;
            last_dz1 = res1_dz;
            n_cmp++;
            if (exp1.size() == 0) begin
                n_fail++;
                $display("FAIL res1_unexpected: got q=%h dz=%b, required none",
                         res1_quotient, res1_dz);
            end else begin
                e = exp1.pop_front();
                if (res1_quotient !== e.q || res1_dz !== e.dz) begin
                    n_fail++;
                    $display("FAIL res1_data: got q=%h dz=%b, required q=%h dz=%b",
                             res1_quotient, res1_dz, e.q, e.dz);
                end
                lat1_last = cyc - e.cyc;
                n_cmp++;
                if (lat1_last < EXP_LAT) begin
                    n_fail++;
                    $display("FAIL res1_latency: got %0d, required >= %0d",
                             lat1_last, EXP_LAT);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic flush_model;
        exp0.delete();
        exp1.delete();
        glog.delete();
        acc0 = 0;
        acc1 = 0;
        pop0_cnt = 0;
        pop1_cnt = 0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        flush_model();
        tick();
        rst_n = 1'b1;
        started = 1'b1;
    endtask

    task automatic rand_ops(input bit allow_zero);
        logic [N-1:0] d;
        for (int k = 0; k < 2; k++) begin
            case ($urandom % 8)
                0: d = allow_zero ? '0 : N'(1);
                1: d = N'($urandom_range(1, 7));
                default: d = N'($urandom);
            endcase
            if (!allow_zero && d == '0) d = N'(3);
            if (k == 0) begin
                req0_dividend = M'($urandom);
                req0_divisor = d;
            end else begin
                req1_dividend = M'($urandom);
                req1_divisor = d;
            end
        end
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        res0_ready = 1'b1;
        res1_ready = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rand_ops(1'b0);
        res0_ready = 1'b1;
        res1_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if ({req0_ready, req1_ready, res0_valid, res1_valid, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 00000",
                     {req0_ready, req1_ready, res0_valid, res1_valid, busy});
        end
        n_cmp++;
        if (div_dividend !== '0 || div_divisor !== N'(1)) begin
            n_fail++;
            $display("FAIL reset_operands: got %h/%h, required 0/1",
                     div_dividend, div_divisor);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        started = 1'b1;
        flush_model();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || res0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got busy=%b v0=%b, required 0 0",
                     busy, res0_valid);
        end
        tick();
    endtask

    task automatic test_single;
        bit ok;
        do_reset();
        req0_dividend = M'(1000000);
        req0_divisor = N'(7);
        req0_valid = 1'b1;
        res0_ready = 1'b1;
        tick();
        req0_valid = 1'b0;
        drain(ok);
        n_cmp++;
        if (!ok || last_q0 !== 26'd142857 || last_dz0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_quot: got q=%0d dz=%b ok=%b, required 142857 0 1",
                     last_q0, last_dz0, ok);
        end
        n_cmp++;
        if (lat0_last != EXP_LAT || pop0_cnt != 1) begin
            n_fail++;
            $display("FAIL single_latency: got %0d pops=%0d, required %0d pops=1",
                     lat0_last, pop0_cnt, EXP_LAT);
        end
    endtask

    task automatic test_alternate;
        bit ok;
        int bad;
        do_reset();
        res0_ready = 1'b1;
        res1_ready = 1'b1;
        rand_ops(1'b0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            rand_ops(1'b0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n_cmp++;
        if (glog.size() != 40) begin
            n_fail++;
            $display("FAIL alt_rate: got %0d issues, required 40", glog.size());
        end
        bad = -1;
        for (int i = 0; i < glog.size(); i++) begin
            if (bad < 0 && glog[i] != i % 2) bad = i;
        end
        n_cmp++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL alt_order: got grant %0d at issue %0d, required %0d",
                     glog[bad], bad, bad % 2);
        end
        drain(ok);
        n_cmp++;
        if (!ok || exp0.size() != 0 || exp1.size() != 0) begin
            n_fail++;
            $display("FAIL alt_drain: got ok=%b left=%0d/%0d, required 1 0/0",
                     ok, exp0.size(), exp1.size());
        end
    endtask

    task automatic test_div_zero;
        bit ok;
        do_reset();
        req1_dividend = M'(5);
        req1_divisor = '0;
        req1_valid = 1'b1;
        res1_ready = 1'b1;
        tick();
        req1_valid = 1'b0;
        drain(ok);
        n_cmp++;
        if (!ok || last_q1 !== 26'h3FFFFFF || last_dz1 !== 1'b1 ||
            pop1_cnt != 1) begin
            n_fail++;
            $display("FAIL dz_result: got q=%h dz=%b pops=%0d, required 3ffffff 1 1",
                     last_q1, last_dz1, pop1_cnt);
        end
        n_cmp++;
        if (zero_seen != 0) begin
            n_fail++;
            $display("FAIL dz_divisor: got %0d zero cycles, required 0",
                     zero_seen);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int mark1;
        do_reset();
        res0_ready = 1'b0;
        res1_ready = 1'b1;
        rand_ops(1'b1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        mark1 = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            rand_ops(1'b1);
            if (acc0 >= 20) req0_valid = 1'b0;
            if (i == 39) mark1 = acc1;
        end
        n_cmp++;
        if (acc0 != 16) begin
            n_fail++;
            $display("FAIL bp_accepted: got %0d, required 16", acc0);
        end
        n_cmp++;
        if (acc1 - mark1 != 10) begin
            n_fail++;
            $display("FAIL bp_other_served: got %0d, required 10",
                     acc1 - mark1);
        end
        req1_valid = 1'b0;
        res0_ready = 1'b1;
        tick();
        res0_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            rand_ops(1'b1);
        end
        n_cmp++;
        if (acc0 != 17 || pop0_cnt != 1) begin
            n_fail++;
            $display("FAIL bp_one_more: got %0d pops=%0d, required 17 pops=1",
                     acc0, pop0_cnt);
        end
        drain(ok);
        n_cmp++;
        if (!ok || exp0.size() != 0 || exp1.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got ok=%b left=%0d/%0d, required 1 0/0",
                     ok, exp0.size(), exp1.size());
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit stale;
        do_reset();
        res0_ready = 1'b1;
        rand_ops(1'b0);
        req0_valid = 1'b1;
        repeat (3) begin
            tick();
            rand_ops(1'b0);
        end
        req0_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        flush_model();
        req0_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({req0_ready, res0_valid, busy} !== 3'b0) begin
            n_fail++;
            $display("FAIL mid_reset_out: got %b, required 000",
                     {req0_ready, res0_valid, busy});
        end
        req0_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res0_valid || res1_valid || busy) stale = 1'b1;
        end
        n_cmp++;
        if (stale) begin
            n_fail++;
            $display("FAIL mid_stale: got activity after reset, required none");
        end
        tick();
        res0_ready = 1'b0;
        req0_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            rand_ops(1'b0);
        end
        n_cmp++;
        if (acc0 != 16) begin
            n_fail++;
            $display("FAIL mid_credits: got %0d, required 16", acc0);
        end
        drain(ok);
        req0_dividend = M'(50000000);
        req0_divisor = N'(321);
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        drain(ok);
        n_cmp++;
        if (!ok || last_q0 !== 26'd155763 || last_dz0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_next_op: got q=%0d ok=%b, required 155763 1",
                     last_q0, ok);
        end
    endtask

    task automatic test_random;
        bit ok;
        int n;
        do_reset();
        n = 0;
        while (acc0 + acc1 < 1000 && n < 20000) begin
            req0_valid = ($urandom % 10) < 7;
            req1_valid = ($urandom % 10) < 7;
            res0_ready = ($urandom % 10) < 7;
            res1_ready = ($urandom % 10) < 7;
            rand_ops(1'b1);
            tick();
            n++;
        end
        n_cmp++;
        if (acc0 + acc1 < 1000) begin
            n_fail++;
            $display("FAIL rand_progress: got %0d ops, required 1000",
                     acc0 + acc1);
        end
        drain(ok);
        n_cmp++;
        if (!ok || pop0_cnt != acc0 || pop1_cnt != acc1) begin
            n_fail++;
            $display("FAIL rand_count: got pops %0d/%0d, required %0d/%0d",
                     pop0_cnt, pop1_cnt, acc0, acc1);
        end
        n_cmp++;
        if (zero_seen != 0) begin
            n_fail++;
            $display("FAIL rand_divisor: got %0d zero cycles, required 0",
                     zero_seen);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        cyc = 0;
        zero_seen = 0;
        started = 1'b0;
        lat0_last = 0;
        lat1_last = 0;
        last_q0 = '0;
        last_q1 = '0;
        last_dz0 = 1'b0;
        last_dz1 = 1'b0;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_dividend = '0;
        req1_dividend = '0;
        req0_divisor = N'(1);
        req1_divisor = N'(1);
        res0_ready = 1'b0;
        res1_ready = 1'b0;
        flush_model();
        test_reset();
        test_single();
        test_alternate();
        test_div_zero();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule
